// File: rtl/sort_pkt_arbiter.sv
// rtl/sort_pkt_arbiter.sv - packet-granular round-robin arbiter sharing one sorter among N_REQ requesters
// Optional statistics counters are built when SORT_ARB_STATS_EN is defined.
module sort_pkt_arbiter #(
    parameter int N_REQ       = 4,
    parameter int DWIDTH      = 16,
    parameter int MAX_PKT_LEN = 13,
    localparam int CWIDTH     = $clog2(N_REQ)
) (
    input  logic                    clk_i,
    input  logic                    arst_n_i,
    input  logic [N_REQ*DWIDTH-1:0] req_data_i,
    input  logic [N_REQ-1:0]        req_startofpacket_i,
    input  logic [N_REQ-1:0]        req_endofpacket_i,
    input  logic [N_REQ-1:0]        req_valid_i,
    output logic [N_REQ-1:0]        req_ready_o,
    output logic [DWIDTH-1:0]       sort_snk_data_o,
    output logic                    sort_snk_sop_o,
    output logic                    sort_snk_eop_o,
    output logic                    sort_snk_valid_o,
    input  logic                    sort_snk_ready_i,
    input  logic [DWIDTH-1:0]       sort_src_data_i,
    input  logic                    sort_src_sop_i,
    input  logic                    sort_src_eop_i,
    input  logic                    sort_src_valid_i,
    output logic                    sort_src_ready_o,
    output logic [DWIDTH-1:0]       out_data_o,
    output logic                    out_sop_o,
    output logic                    out_eop_o,
    output logic                    out_valid_o,
    output logic [CWIDTH-1:0]       out_channel_o,
    input  logic                    out_ready_i,
`ifdef SORT_ARB_STATS_EN
    input  logic                    stat_clr_i,
    output logic [15:0]             stat_pkt_cnt_o,
    output logic [15:0]             stat_err_cnt_o,
`endif
    output logic                    busy_o
);

    localparam int CNT_W = $clog2(MAX_PKT_LEN + 1);

    typedef enum logic [1:0] {
        IDLE_S,
        FWD_S,
        DRAIN_S,
        WAIT_S
    } state_t;

    state_t            state_q, state_d;
    logic [CWIDTH-1:0] grant_q, grant_d;
    logic [CWIDTH-1:0] last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;

    logic              found;
    logic [CWIDTH-1:0] winner;
    logic [CWIDTH-1:0] cand;

    logic [DWIDTH-1:0] g_data;
    logic              g_sop, g_eop, g_valid;
    logic              at_max;

    logic [N_REQ-1:0]  ready_raw;
    logic [DWIDTH-1:0] snk_data;
    logic              snk_valid_raw, snk_sop_raw, snk_eop_raw;
    logic              src_ready_raw;
    logic [DWIDTH-1:0] out_data;
    logic              out_valid_raw, out_sop_raw, out_eop_raw;
    logic              pkt_done, trunc;
    logic [N_REQ-1:0]  idle_drop;

    // Rotating priority: first SOP-valid requester after the last one served.
    always_comb begin
        found  = 1'b0;
        winner = last_grant_q;
        cand   = last_grant_q;
        for (int i = 0; i < N_REQ; i++) begin
            cand = (cand == CWIDTH'(N_REQ - 1)) ? '0 : cand + 1'b1;
            if (!found && req_valid_i[cand] && req_startofpacket_i[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        g_data  = req_data_i[int'(grant_q)*DWIDTH +: DWIDTH];
        g_sop   = req_startofpacket_i[grant_q];
        g_eop   = req_endofpacket_i[grant_q];
        g_valid = req_valid_i[grant_q];
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        word_cnt_d    = word_cnt_q;
        ready_raw     = '0;
        snk_data      = '0;
        snk_valid_raw = 1'b0;
        snk_sop_raw   = 1'b0;
        snk_eop_raw   = 1'b0;
        src_ready_raw = 1'b0;
        out_data      = '0;
        out_valid_raw = 1'b0;
        out_sop_raw   = 1'b0;
        out_eop_raw   = 1'b0;
        pkt_done      = 1'b0;
        trunc         = 1'b0;
        idle_drop     = '0;
        at_max        = (word_cnt_q == CNT_W'(MAX_PKT_LEN - 1));

        unique case (state_q)
            IDLE_S: begin
                // SOP beats wait for the grant; stray mid-packet beats are flushed.
                for (int r = 0; r < N_REQ; r++) begin
                    if (req_valid_i[r] && !req_startofpacket_i[r]) begin
                        ready_raw[r] = 1'b1;
                        idle_drop[r] = 1'b1;
                    end
                end
                if (found) begin
                    grant_d = winner;
                    state_d = FWD_S;
                end
            end
            FWD_S: begin
                snk_data           = g_data;
                snk_valid_raw      = g_valid;
                snk_sop_raw        = g_sop && (word_cnt_q == '0);
                snk_eop_raw        = g_eop || at_max;
                ready_raw[grant_q] = sort_snk_ready_i;
                if (g_valid && sort_snk_ready_i) begin
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (g_eop) begin
                        state_d = WAIT_S;
                    end else if (at_max) begin
                        trunc   = 1'b1;
                        state_d = DRAIN_S;
                    end
                end
            end
            DRAIN_S: begin
                ready_raw[grant_q] = 1'b1;
                if (g_valid && g_eop) begin
                    state_d = WAIT_S;
                end
            end
            WAIT_S: begin
                out_data      = sort_src_data_i;
                out_valid_raw = sort_src_valid_i;
                out_sop_raw   = sort_src_sop_i;
                out_eop_raw   = sort_src_eop_i;
                src_ready_raw = out_ready_i;
                if (sort_src_valid_i && out_ready_i && sort_src_eop_i) begin
                    state_d      = IDLE_S;
                    last_grant_d = grant_q;
                    word_cnt_d   = '0;
                    pkt_done     = 1'b1;
                end
            end
            default: state_d = IDLE_S;
        endcase
    end

    // Handshake outputs are forced low for the whole time reset is asserted.
    assign req_ready_o      = ready_raw & {N_REQ{arst_n_i}};
    assign sort_snk_data_o  = snk_data;
    assign sort_snk_valid_o = snk_valid_raw & arst_n_i;
    assign sort_snk_sop_o   = snk_sop_raw & arst_n_i;
    assign sort_snk_eop_o   = snk_eop_raw & arst_n_i;
    assign sort_src_ready_o = src_ready_raw & arst_n_i;
    assign out_data_o       = out_data;
    assign out_valid_o      = out_valid_raw & arst_n_i;
    assign out_sop_o        = out_sop_raw & arst_n_i;
    assign out_eop_o        = out_eop_raw & arst_n_i;
    assign out_channel_o    = grant_q;
    assign busy_o           = (state_q != IDLE_S);

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q      <= IDLE_S;
            grant_q      <= '0;
            last_grant_q <= CWIDTH'(N_REQ - 1);
            word_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            word_cnt_q   <= word_cnt_d;
        end
    end

`ifdef SORT_ARB_STATS_EN
    logic [15:0]       pkt_cnt_q, pkt_cnt_d;
    logic [15:0]       err_cnt_q, err_cnt_d;
    logic [CWIDTH+1:0] err_inc;
    logic [16:0]       err_sum;

    // Several requesters can be flushed in the same idle cycle, so errors add up per beat.
    always_comb begin
        err_inc = {{(CWIDTH + 1){1'b0}}, trunc};
        for (int r = 0; r < N_REQ; r++) begin
            err_inc = err_inc + {{(CWIDTH + 1){1'b0}}, idle_drop[r]};
        end
        err_sum   = {1'b0, err_cnt_q} + 17'(err_inc);
        err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
        pkt_cnt_d = pkt_cnt_q;
        if (pkt_done && (pkt_cnt_q != 16'hFFFF)) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
        end
        if (stat_clr_i) begin
            pkt_cnt_d = '0;
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            pkt_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign stat_pkt_cnt_o = pkt_cnt_q;
    assign stat_err_cnt_o = err_cnt_q;
`else
    logic stats_unused;
    assign stats_unused = ^{trunc, idle_drop, pkt_done};
`endif

endmodule

// File: tb/tb_sort_pkt_arbiter.sv
// tb/tb_sort_pkt_arbiter.sv - scoreboard bench for sort_pkt_arbiter with a behavioural sorter model
module tb_sort_pkt_arbiter;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int ML = 13;

    typedef logic [DW-1:0] wq_t[$];
    typedef struct packed { logic [DW-1:0] d; logic sop; logic eop; } beat_t;
    typedef struct packed { logic [1:0] ch; logic [DW-1:0] d; logic sop; logic eop; } exp_t;

    logic            clk = 1'b0;
    logic            arst_n = 1'b0;
    logic [N*DW-1:0] req_data_i;
    logic [N-1:0]    req_sop_i, req_eop_i, req_valid_i, req_ready_o;
    logic [DW-1:0]   sort_snk_data_o;
    logic            sort_snk_sop_o, sort_snk_eop_o, sort_snk_valid_o, sort_snk_ready_i;
    logic [DW-1:0]   sort_src_data_i;
    logic            sort_src_sop_i, sort_src_eop_i, sort_src_valid_i, sort_src_ready_o;
    logic [DW-1:0]   out_data_o;
    logic            out_sop_o, out_eop_o, out_valid_o, out_ready_i;
    logic [1:0]      out_channel_o;
    logic            busy_o;
`ifdef SORT_ARB_STATS_EN
    logic            stat_clr_i;
    logic [15:0]     stat_pkt_cnt_o, stat_err_cnt_o;
`endif

    int    checks = 0;
    int    fails = 0;
    beat_t rq[N][$];
    exp_t  sb[$];
    wq_t   sbuf;
    beat_t sout[$];
    bit    tog_en = 1'b0;
    int    snk_words = 0;
    int    last_len = 0;

    always #5 clk = ~clk;

    sort_pkt_arbiter #(.N_REQ(N), .DWIDTH(DW), .MAX_PKT_LEN(ML)) dut (
        .clk_i               (clk),
        .arst_n_i            (arst_n),
        .req_data_i          (req_data_i),
        .req_startofpacket_i (req_sop_i),
        .req_endofpacket_i   (req_eop_i),
        .req_valid_i         (req_valid_i),
        .req_ready_o         (req_ready_o),
        .sort_snk_data_o     (sort_snk_data_o),
        .sort_snk_sop_o      (sort_snk_sop_o),
        .sort_snk_eop_o      (sort_snk_eop_o),
        .sort_snk_valid_o    (sort_snk_valid_o),
        .sort_snk_ready_i    (sort_snk_ready_i),
        .sort_src_data_i     (sort_src_data_i),
        .sort_src_sop_i      (sort_src_sop_i),
        .sort_src_eop_i      (sort_src_eop_i),
        .sort_src_valid_i    (sort_src_valid_i),
        .sort_src_ready_o    (sort_src_ready_o),
        .out_data_o          (out_data_o),
        .out_sop_o           (out_sop_o),
        .out_eop_o           (out_eop_o),
        .out_valid_o         (out_valid_o),
        .out_channel_o       (out_channel_o),
        .out_ready_i         (out_ready_i),
`ifdef SORT_ARB_STATS_EN
        .stat_clr_i          (stat_clr_i),
        .stat_pkt_cnt_o      (stat_pkt_cnt_o),
        .stat_err_cnt_o      (stat_err_cnt_o),
`endif
        .busy_o              (busy_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic sort_q(input wq_t a, output wq_t s);
        s = {};
        foreach (a[i]) begin
            int p = 0;
            while (p < s.size() && s[p] <= a[i]) p++;
            s.insert(p, a[i]);
        end
    endtask

    // Queue a packet on requester r; when exp_en, push its sorted, truncated image to the scoreboard.
    task automatic send(input int r, input wq_t w, input bit exp_en);
        wq_t   kept;
        wq_t   srt;
        beat_t b;
        exp_t  e;
        foreach (w[i]) begin
            b.d   = w[i];
            b.sop = (i == 0);
            b.eop = (i == w.size() - 1);
            rq[r].push_back(b);
            if (i < ML) kept.push_back(w[i]);
        end
        if (exp_en) begin
            sort_q(kept, srt);
            foreach (srt[i]) begin
                e.ch  = 2'(r);
                e.d   = srt[i];
                e.sop = (i == 0);
                e.eop = (i == srt.size() - 1);
                sb.push_back(e);
            end
        end
    endtask

    function automatic bit rq_empty();
        for (int r = 0; r < N; r++) if (rq[r].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_done(input string tag);
        bit ok = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            #2;
            if (sb.size() == 0 && rq_empty() && !busy_o) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_done"}, 64'(ok), 64'd1);
    endtask

    // Requester drivers, sorter model and output monitor, all sampled on the falling edge.
    initial begin
        logic [N-1:0]  rfire;
        bit            snk_f, src_f, out_f;
        logic [DW-1:0] snk_d;
        logic          snk_s, snk_e;
        exp_t          e;
        wq_t           srt;
        beat_t         b;
        req_data_i       = '0;
        req_sop_i        = '0;
        req_eop_i        = '0;
        req_valid_i      = '0;
        sort_snk_ready_i = 1'b1;
        sort_src_data_i  = '0;
        sort_src_sop_i   = 1'b0;
        sort_src_eop_i   = 1'b0;
        sort_src_valid_i = 1'b0;
        out_ready_i      = 1'b1;
        forever begin
            @(negedge clk);
            rfire = req_valid_i & req_ready_o;
            snk_f = sort_snk_valid_o & sort_snk_ready_i;
            snk_d = sort_snk_data_o;
            snk_s = sort_snk_sop_o;
            snk_e = sort_snk_eop_o;
            src_f = sort_src_valid_i & sort_src_ready_o;
            out_f = out_valid_o & out_ready_i;
            if (out_valid_o) chk("src_ready_track", 64'(sort_src_ready_o), 64'(out_ready_i));
            if (out_f) begin
                if (sb.size() == 0) begin
                    chk("out_unexpected", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", 64'(out_data_o), 64'(e.d));
                    chk("out_channel", 64'(out_channel_o), 64'(e.ch));
                    chk("out_sop", 64'(out_sop_o), 64'(e.sop));
                    chk("out_eop", 64'(out_eop_o), 64'(e.eop));
                end
            end
            if (snk_f) begin
                chk("snk_sop", 64'(snk_s), 64'(snk_words == 0));
                snk_words++;
                if (snk_e) begin
                    last_len  = snk_words;
                    snk_words = 0;
                end
            end
            @(posedge clk);
            #1;
            if (!arst_n) snk_words = 0;
            for (int r = 0; r < N; r++) if (rfire[r] && rq[r].size() > 0) void'(rq[r].pop_front());
            if (src_f && sout.size() > 0) void'(sout.pop_front());
            if (snk_f) begin
                if (snk_s) sbuf.delete();
                sbuf.push_back(snk_d);
                if (snk_e) begin
                    sort_q(sbuf, srt);
                    foreach (srt[i]) begin
                        b.d   = srt[i];
                        b.sop = (i == 0);
                        b.eop = (i == srt.size() - 1);
                        sout.push_back(b);
                    end
                    sbuf.delete();
                end
            end
            for (int r = 0; r < N; r++) begin
                if (rq[r].size() > 0) begin
                    req_valid_i[r]           = 1'b1;
                    req_data_i[r*DW +: DW]   = rq[r][0].d;
                    req_sop_i[r]             = rq[r][0].sop;
                    req_eop_i[r]             = rq[r][0].eop;
                end else begin
                    req_valid_i[r] = 1'b0;
                    req_sop_i[r]   = 1'b0;
                    req_eop_i[r]   = 1'b0;
                end
            end
            sort_snk_ready_i = (sout.size() == 0);
            if (sout.size() > 0) begin
                sort_src_valid_i = 1'b1;
                sort_src_data_i  = sout[0].d;
                sort_src_sop_i   = sout[0].sop;
                sort_src_eop_i   = sout[0].eop;
            end else begin
                sort_src_valid_i = 1'b0;
                sort_src_sop_i   = 1'b0;
                sort_src_eop_i   = 1'b0;
            end
            out_ready_i = tog_en ? ~out_ready_i : 1'b1;
        end
    end

    initial begin
        wq_t w;
        bit  hit;
`ifdef SORT_ARB_STATS_EN
        stat_clr_i = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #3;
        chk("rst_req_ready", 64'(req_ready_o), 64'd0);
        chk("rst_snk_valid", 64'(sort_snk_valid_o), 64'd0);
        chk("rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst_src_ready", 64'(sort_src_ready_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        arst_n = 1'b1;

        w = {16'd9, 16'd3, 16'd7, 16'd1, 16'd5};
        send(0, w, 1'b1);
        wait_done("basic");
        chk("basic_busy_low", 64'(busy_o), 64'd0);

        w = {16'd4, 16'd2};          send(1, w, 1'b1);
        w = {16'd8, 16'd6, 16'd7};   send(2, w, 1'b1);
        w = {16'd11, 16'd10};        send(3, w, 1'b1);
        wait_done("rr_123");
        w = {16'd20, 16'd15};        send(0, w, 1'b1);
        w = {16'd30, 16'd25, 16'd27}; send(1, w, 1'b1);
        wait_done("rr_01");

        w = {};
        for (int i = 0; i < 16; i++) w.push_back(16'((i * 37 + 11) % 64));
        send(2, w, 1'b1);
        wait_done("trunc");
        chk("trunc_len", 64'(last_len), 64'd13);
`ifdef SORT_ARB_STATS_EN
        chk("stat_err", 64'(stat_err_cnt_o), 64'd1);
        chk("stat_pkt", 64'(stat_pkt_cnt_o), 64'd7);
`endif

        w = {16'h00AA};
        send(3, w, 1'b1);
        wait_done("single");

        tog_en = 1'b1;
        w = {16'd60, 16'd12, 16'd33, 16'd12, 16'd5, 16'd41};
        send(1, w, 1'b1);
        wait_done("toggle");
        tog_en = 1'b0;

`ifdef SORT_ARB_STATS_EN
        @(posedge clk);
        #3 stat_clr_i = 1'b1;
        @(posedge clk);
        #3 stat_clr_i = 1'b0;
        chk("stat_clr_pkt", 64'(stat_pkt_cnt_o), 64'd0);
        chk("stat_clr_err", 64'(stat_err_cnt_o), 64'd0);
`endif

        w = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
        send(0, w, 1'b0);
        hit = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            #2;
            if (snk_words >= 3) begin
                hit = 1'b1;
                break;
            end
        end
        chk("rst_mid_reached_fwd", 64'(hit), 64'd1);
        @(posedge clk);
        #3 arst_n = 1'b0;
        #1;
        chk("rst_mid_req_ready", 64'(req_ready_o), 64'd0);
        chk("rst_mid_snk_valid", 64'(sort_snk_valid_o), 64'd0);
        chk("rst_mid_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst_mid_busy", 64'(busy_o), 64'd0);
        rq[0].delete();
        repeat (2) @(posedge clk);
        #3 arst_n = 1'b1;
        w = {16'd5, 16'd2, 16'd8};
        send(0, w, 1'b1);
        wait_done("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
